// File: rtl/core_link_arbiter.sv
// -----------------------------------------------------------------------------
// core_link_arbiter
//   Round-robin arbiter that forwards one message word at a time from one of
//   NCORES requesting cores to a single destination. It has three states:
//     IDLE    - pick a requester and latch its word
//     SEND    - present the word until the destination acks, or until TIMEOUT
//     RELEASE - hold req_ack until the requester and the destination both let go
//   All outputs are driven from registers.
//
// Ports
//   Clock_pin    in   rising-edge clock
//   Resetn_pin   in   asynchronous active-low reset
//   req_valid    in   [NCORES]     per-core request level
//   req_data     in   [NCORES*DW]  per-core message; core i at [i*DW +: DW]
//   req_ack      out  [NCORES]     one-hot acknowledge to the granted core
//   out_data     out  [DW]         latched message toward the destination
//   out_valid    out               message present on out_data
//   out_ack      in                destination consumed the message (level)
//   grant_id     out  [2]          index of the granted core
//   busy         out               high whenever not in IDLE
//   err_clr      in                synchronous clear of timeout_err
//   timeout_err  out               sticky SEND-timeout flag
// -----------------------------------------------------------------------------
module core_link_arbiter #(
    parameter int NCORES  = 4,
    parameter int DW      = 14,
    parameter int TIMEOUT = 1024
) (
    input  logic                 Clock_pin,
    input  logic                 Resetn_pin,
    input  logic [NCORES-1:0]    req_valid,
    input  logic [NCORES*DW-1:0] req_data,
    output logic [NCORES-1:0]    req_ack,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic [1:0]           grant_id,
    output logic                 busy,
    input  logic                 err_clr,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [15:0] LP_CNT_MAX = 16'(TIMEOUT - 1);
    localparam logic [1:0]  LP_LAST    = 2'(NCORES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_rr_ptr;
    logic [1:0]          r_grant;
    logic [15:0]         r_cnt;
    logic [DW-1:0]       r_out_data;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_err;
    logic [NCORES-1:0]   r_req_ack;

    logic [2*NCORES-1:0] w_rot;
    logic                w_any;
    int                  w_off;
    int                  w_sum;
    logic [1:0]          w_sel;
    logic [NCORES-1:0]   w_grant_mask;
    logic                w_grant_valid;
    logic                w_timeout_hit;
    logic                w_release_done;
    logic [1:0]          w_next_ptr;

    // Rotate the request vector so bit 0 is the core at rr_ptr; the first set
    // bit then gives the offset of the winner from rr_ptr.
    always_comb begin
        w_rot = {req_valid, req_valid} >> r_rr_ptr;
        w_any = 1'b0;
        w_off = 0;
        for (int k = 0; k < NCORES; k++) begin
            if (!w_any && w_rot[k]) begin
                w_any = 1'b1;
                w_off = k;
            end
        end
        w_sum = int'(r_rr_ptr) + w_off;
        if (w_sum >= NCORES) begin
            w_sum = w_sum - NCORES;
        end
        w_sel = w_sum[1:0];
    end

    assign w_grant_mask   = NCORES'(1) << r_grant;
    assign w_grant_valid  = |(req_valid & w_grant_mask);
    // out_ack in the final counted cycle still counts as a delivery.
    assign w_timeout_hit  = (r_state == ST_SEND) && (r_cnt == LP_CNT_MAX) && !out_ack;
    assign w_release_done = !w_grant_valid && !out_ack;
    assign w_next_ptr     = (r_grant == LP_LAST) ? 2'd0 : r_grant + 2'd1;

    // State register
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ack) begin
                    w_next_state = ST_RELEASE;
                end else if (w_timeout_hit) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (w_release_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Registered datapath and output flops
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_req_ack   <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_out_valid <= 1'b0;
                    r_req_ack   <= '0;
                    if (w_any) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= req_data[int'(w_sel)*DW +: DW];
                        r_grant     <= w_sel;
                        r_cnt       <= '0;
                    end
                end
                ST_SEND: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (out_ack) begin
                        r_out_valid <= 1'b0;
                        r_req_ack   <= w_grant_mask;
                    end else if (w_timeout_hit) begin
                        r_out_valid <= 1'b0;
                        r_rr_ptr    <= w_next_ptr;
                    end
                end
                ST_RELEASE: begin
                    if (w_release_done) begin
                        r_req_ack <= '0;
                        r_rr_ptr  <= w_next_ptr;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_req_ack   <= '0;
                end
            endcase

            r_busy <= (w_next_state != ST_IDLE);

            // A timeout in the same cycle as err_clr leaves the flag set.
            if (w_timeout_hit) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Output logic
    always_comb begin
        req_ack     = r_req_ack;
        out_data    = r_out_data;
        out_valid   = r_out_valid;
        grant_id    = r_grant;
        busy        = r_busy;
        timeout_err = r_err;
    end

endmodule

// File: tb/tb_core_link_arbiter.sv
`timescale 1ns/1ps
module tb_core_link_arbiter;

    localparam int NC   = 4;
    localparam int DW   = 14;
    localparam int TO   = 8;
    localparam int WLIM = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NC-1:0]    req_valid;
    logic [NC*DW-1:0] req_data;
    logic [NC-1:0]    req_ack;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ack;
    logic [1:0]       grant_id;
    logic             busy;
    logic             err_clr;
    logic             timeout_err;

    int checks   = 0;
    int failures = 0;
    int model_rr = 0;
    int g;
    int cyc;

    logic [DW-1:0] core_d [NC];
    logic [15:0]   exp_q [$];
    logic [15:0]   exp_item;

    core_link_arbiter #(.NCORES(NC), .DW(DW), .TIMEOUT(TO)) dut (
        .Clock_pin   (clk),
        .Resetn_pin  (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ack     (out_ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_clr     (err_clr),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference round-robin choice: first requesting index at or after rr.
    function automatic int pick(input logic [NC-1:0] v, input int rr);
        for (int k = 0; k < NC; k++) begin
            if (v[(rr + k) % NC]) return (rr + k) % NC;
        end
        return 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_data;
        for (int i = 0; i < NC; i++) req_data[i*DW +: DW] = core_d[i];
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < WLIM) begin
            tick();
            n++;
        end
    endtask

    task automatic push_expect;
        g = pick(req_valid, model_rr);
        exp_q.push_back({2'(g), core_d[g]});
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '0; req_data = '0; out_ack = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < NC; i++) core_d[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        checks++; if (req_ack !== '0) begin failures++; $display("FAIL rst_req_ack: got %b want 0000", req_ack); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", timeout_err); end
        rst_n = 1'b1; model_rr = 0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_rst: busy got %b want 0", busy); end
    endtask

    task automatic test_single;
        core_d[0] = 14'h0155; apply_data();
        req_valid = 4'b0001;
        push_expect();
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_latency: out_valid got %b want 1", out_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
        exp_item = exp_q.pop_front();
        checks++; if ({grant_id, out_data} !== exp_item) begin failures++;
            $display("FAIL single_data: got grant=%0d data=%h want grant=%0d data=%h", grant_id, out_data, exp_item[15:14], exp_item[13:0]); end
        out_ack = 1'b1;
        tick();
        checks++; if ({out_valid, req_ack} !== 5'b0_0001) begin failures++; $display("FAIL single_ack: got valid=%b ack=%b want valid=0 ack=0001", out_valid, req_ack); end
        req_valid = '0; out_ack = 1'b0;
        tick();
        checks++; if ({busy, req_ack} !== 5'b0_0000) begin failures++; $display("FAIL single_release: got busy=%b ack=%b want 0/0000", busy, req_ack); end
        model_rr = (g + 1) % NC;
    endtask

    task automatic test_rotation;
        rst_n = 1'b0; tick(); rst_n = 1'b1; model_rr = 0;
        core_d[0] = 14'h0A01; core_d[1] = 14'h0B12; core_d[2] = 14'h0C23; core_d[3] = 14'h0D34;
        apply_data();
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            push_expect();
            wait_valid(cyc);
            checks++; if (cyc >= WLIM) begin failures++; $display("FAIL rot_wait%0d: waited %0d cycles, limit %0d", t, cyc, WLIM); end
            exp_item = exp_q.pop_front();
            checks++; if ({grant_id, out_data} !== exp_item) begin failures++;
                $display("FAIL rot_grant%0d: got grant=%0d data=%h want grant=%0d data=%h", t, grant_id, out_data, exp_item[15:14], exp_item[13:0]); end
            out_ack = 1'b1;
            tick();
            checks++; if (req_ack !== (4'b0001 << g)) begin failures++; $display("FAIL rot_ack%0d: got %b want %b", t, req_ack, 4'b0001 << g); end
            if (t == 4) req_valid = '0;
            else req_valid[g] = 1'b0;
            out_ack = 1'b0;
            tick();
            model_rr = (g + 1) % NC;
            if (t != 4) req_valid = 4'b1111;
        end
    endtask

    task automatic test_timeout;
        int  n;
        logic ack_seen;
        core_d[2] = 14'h2AAA; core_d[3] = 14'h3555; apply_data();
        req_valid = 4'b0100;
        push_expect();
        wait_valid(cyc);
        checks++; if (cyc >= WLIM) begin failures++; $display("FAIL to_wait: waited %0d cycles, limit %0d", cyc, WLIM); end
        exp_item = exp_q.pop_front();
        checks++; if ({grant_id, out_data} !== exp_item) begin failures++;
            $display("FAIL to_grant: got grant=%0d data=%h want grant=%0d data=%h", grant_id, out_data, exp_item[15:14], exp_item[13:0]); end
        n = 0; ack_seen = 1'b0;
        while (out_valid === 1'b1 && n < 30) begin
            n++;
            if (req_ack !== '0) ack_seen = 1'b1;
            tick();
        end
        checks++; if (n !== TO) begin failures++; $display("FAIL to_len: out_valid high %0d cycles want %0d", n, TO); end
        checks++; if (ack_seen !== 1'b0 || req_ack !== '0) begin failures++; $display("FAIL to_no_ack: req_ack seen=%b now=%b want 0", ack_seen, req_ack); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
        model_rr = (g + 1) % NC;

        req_valid = 4'b1100;
        push_expect();
        wait_valid(cyc);
        checks++; if (cyc >= WLIM) begin failures++; $display("FAIL to_next_wait: waited %0d cycles, limit %0d", cyc, WLIM); end
        exp_item = exp_q.pop_front();
        checks++; if ({grant_id, out_data} !== exp_item) begin failures++;
            $display("FAIL to_next_grant: got grant=%0d data=%h want grant=%0d data=%h", grant_id, out_data, exp_item[15:14], exp_item[13:0]); end
        out_ack = 1'b1;
        tick();
        checks++; if (req_ack !== 4'b1000) begin failures++; $display("FAIL to_next_ack: got %b want 1000", req_ack); end
        req_valid = 4'b0100; out_ack = 1'b0;
        model_rr = (g + 1) % NC;
        push_expect();
        tick();
        checks++; if (req_ack !== '0) begin failures++; $display("FAIL to_next_rel: got %b want 0000", req_ack); end

        wait_valid(cyc);
        checks++; if (cyc >= WLIM) begin failures++; $display("FAIL to2_wait: waited %0d cycles, limit %0d", cyc, WLIM); end
        exp_item = exp_q.pop_front();
        checks++; if ({grant_id, out_data} !== exp_item) begin failures++;
            $display("FAIL to2_grant: got grant=%0d data=%h want grant=%0d data=%h", grant_id, out_data, exp_item[15:14], exp_item[13:0]); end
        err_clr = 1'b1;
        tick();
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL err_clr: got %b want 0", timeout_err); end
        n = 0;
        while (out_valid === 1'b1 && n < 30) begin
            n++;
            tick();
        end
        checks++; if (n !== TO - 1) begin failures++; $display("FAIL to2_len: remaining high %0d cycles want %0d", n, TO - 1); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL err_set_wins: got %b want 1", timeout_err); end
        model_rr = (g + 1) % NC;

        push_expect();
        wait_valid(cyc);
        checks++; if (cyc >= WLIM) begin failures++; $display("FAIL to3_wait: waited %0d cycles, limit %0d", cyc, WLIM); end
        exp_item = exp_q.pop_front();
        checks++; if ({grant_id, out_data} !== exp_item) begin failures++;
            $display("FAIL to3_regrant: got grant=%0d data=%h want grant=%0d data=%h", grant_id, out_data, exp_item[15:14], exp_item[13:0]); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL err_clr2: got %b want 0", timeout_err); end
        err_clr = 1'b0;
        out_ack = 1'b1;
        tick();
        req_valid = '0; out_ack = 1'b0;
        tick();
        model_rr = (g + 1) % NC;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to3_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_abort;
        core_d[1] = 14'h1234; apply_data();
        req_valid = 4'b0010;
        push_expect();
        wait_valid(cyc);
        checks++; if (cyc >= WLIM) begin failures++; $display("FAIL ab_wait: waited %0d cycles, limit %0d", cyc, WLIM); end
        exp_item = exp_q.pop_front();
        checks++; if ({grant_id, out_data} !== exp_item) begin failures++;
            $display("FAIL ab_grant: got grant=%0d data=%h want grant=%0d data=%h", grant_id, out_data, exp_item[15:14], exp_item[13:0]); end
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if ({out_valid, out_data} !== {1'b1, core_d[1]}) begin failures++;
                $display("FAIL ab_hold%0d: got valid=%b data=%h want 1/%h", k, out_valid, out_data, core_d[1]); end
        end
        out_ack = 1'b1;
        tick();
        checks++; if (req_ack !== 4'b0010) begin failures++; $display("FAIL ab_ack: got %b want 0010", req_ack); end
        tick();
        checks++; if (req_ack !== 4'b0010) begin failures++; $display("FAIL ab_ack_hold: got %b want 0010", req_ack); end
        out_ack = 1'b0;
        tick();
        checks++; if ({busy, req_ack} !== 5'b0_0000) begin failures++; $display("FAIL ab_release: got busy=%b ack=%b want 0/0000", busy, req_ack); end
        model_rr = (g + 1) % NC;
    endtask

    task automatic test_reset_mid;
        core_d[1] = 14'h0111; core_d[3] = 14'h3ABC; apply_data();
        req_valid = 4'b1010;
        push_expect();
        wait_valid(cyc);
        checks++; if (cyc >= WLIM) begin failures++; $display("FAIL rm_wait: waited %0d cycles, limit %0d", cyc, WLIM); end
        exp_item = exp_q.pop_front();
        checks++; if ({grant_id, out_data} !== exp_item) begin failures++;
            $display("FAIL rm_grant: got grant=%0d data=%h want grant=%0d data=%h", grant_id, out_data, exp_item[15:14], exp_item[13:0]); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, busy, req_ack} !== 6'b0) begin failures++; $display("FAIL rm_async_ctl: got valid=%b busy=%b ack=%b want all 0", out_valid, busy, req_ack); end
        checks++; if ({grant_id, out_data} !== 16'h0) begin failures++; $display("FAIL rm_async_data: got grant=%0d data=%h want 0/0", grant_id, out_data); end
        @(posedge clk);
        #1;
        rst_n = 1'b1; model_rr = 0;
        push_expect();
        wait_valid(cyc);
        checks++; if (cyc >= WLIM) begin failures++; $display("FAIL rm2_wait: waited %0d cycles, limit %0d", cyc, WLIM); end
        exp_item = exp_q.pop_front();
        checks++; if ({grant_id, out_data} !== exp_item) begin failures++;
            $display("FAIL rm2_grant: got grant=%0d data=%h want grant=%0d data=%h", grant_id, out_data, exp_item[15:14], exp_item[13:0]); end
        out_ack = 1'b1;
        tick();
        req_valid = '0; out_ack = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm2_idle: busy got %b want 0", busy); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain: %0d entries left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
